// File: rtl/mips_imem_loader.sv
// Boot loader: stream LEN_HI, LEN_LO, N big-endian 32-bit words[, CSUM] -> imem writes, then release core.
// Define LOADER_CSUM_EN to require a trailing XOR checksum byte.
module mips_imem_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);
  localparam int unsigned    CNT_W = 16;
  localparam logic [CNT_W:0] ONE_N = 1;
  localparam logic [CNT_W:0] MAX_N = (ADDR_W < CNT_W) ? (ONE_N << ADDR_W) : '1;

  typedef enum logic [2:0] {
    S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   wcnt_q, wcnt_d;
  logic [1:0]         bcnt_q, bcnt_d;
  logic [23:0]        asm_q, asm_d;
  logic               in_ready_q, in_ready_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               cpu_rst_q, cpu_rst_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               accept;
`ifdef LOADER_CSUM_EN
  logic [7:0]         xor_q, xor_d;
`endif

  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef LOADER_CSUM_EN
    xor_d   = xor_q;
`endif
    if (accept) begin
`ifdef LOADER_CSUM_EN
      if (state_q != S_CSUM) xor_d = xor_q ^ in_data;
`endif
      case (state_q)
        S_LEN_HI: begin
          len_d[15:8] = in_data;
          state_d     = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_d[7:0] = in_data;
          if ({1'b0, len_q[15:8], in_data} > MAX_N)
            state_d = S_ERR;
          else if ({len_q[15:8], in_data} == '0)
`ifdef LOADER_CSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          else
            state_d = S_DATA;
        end
        S_DATA: begin
          asm_d  = {asm_q[15:0], in_data};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = ADDR_W'(wcnt_q);
            wdata_d = {asm_q, in_data};
            wcnt_d  = wcnt_q + 16'd1;
            if (wcnt_d == len_q)
`ifdef LOADER_CSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_DONE;
`endif
          end
        end
`ifdef LOADER_CSUM_EN
        S_CSUM: state_d = (in_data == xor_q) ? S_DONE : S_ERR;
`endif
        default: ;
      endcase
    end
    // Holding done off while the final write is issued delays it one cycle past that write.
    done_d     = (state_d == S_DONE) && !we_d;
    err_d      = (state_d == S_ERR);
    cpu_rst_d  = !done_d;
    in_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                 (state_d == S_DATA)   || (state_d == S_CSUM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_LEN_HI;
      len_q      <= '0;
      wcnt_q     <= '0;
      bcnt_q     <= '0;
      asm_q      <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef LOADER_CSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wcnt_q     <= wcnt_d;
      bcnt_q     <= bcnt_d;
      asm_q      <= asm_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef LOADER_CSUM_EN
      xor_q      <= xor_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mips_imem_loader.sv
// Self-checking bench for mips_imem_loader; follows LOADER_CSUM_EN when defined for the build.
`timescale 1ns/1ps
module tb_mips_imem_loader;
`ifdef LOADER_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif
  localparam int unsigned ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              err;

  mips_imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] addr; logic [31:0] data; } wr_t;
  typedef struct {
    int unsigned len; int unsigned gap; bit bad_csum; bit exp_done; bit exp_err;
  } vec_t;

  wr_t  sb[$];
  vec_t vecs[7];
  int   checks = 0;
  int   errors = 0;
  int   cur_vec = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (vec %0d): got 0x%0h expected 0x%0h", name, cur_vec, act, exp);
    end
  endtask

  // Scoreboard: every observed write must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_we) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write (vec %0d): addr 0x%0h data 0x%0h, none expected",
                 cur_vec, imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", {24'd0, imem_addr}, {24'd0, e.addr});
        chk("wr_data", imem_wdata, e.data);
      end
    end
  end

  function automatic logic [31:0] word_of(input int unsigned i);
    if (i == 0) return 32'h20010005;
    if (i == 1) return 32'h20020007;
    return 32'hA5000000 ^ (i * 32'h01030507);
  endfunction

  task automatic send(input logic [7:0] b, input int unsigned gap, inout logic [7:0] x);
    int unsigned n;
    bit ok;
    if (gap > 0) begin
      n = $urandom_range(0, gap);
      repeat (n) @(posedge clk);
      #1;
    end
    in_data  = b;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout (vec %0d): in_ready 0 for 20 cycles, required 1", cur_vec);
    end
    x = x ^ b;
  endtask

  task automatic do_reset();
    sb.delete();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_we", imem_we, 0);
    chk("rst_addr", {24'd0, imem_addr}, 0);
    chk("rst_wdata", imem_wdata, 0);
    @(negedge clk);
    chk("rdy_after_rst", in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0]  x;
    logic [31:0] w;
    bit          ovf;
    x = '0;
    ovf = v.len > (1 << ADDR_W);
    send(v.len[15:8], v.gap, x);
    send(v.len[7:0], v.gap, x);
    if (!ovf) begin
      for (int unsigned i = 0; i < v.len; i++) begin
        w = word_of(i);
        sb.push_back('{addr: i[7:0], data: w});
        for (int k = 3; k >= 0; k--) send(w[8*k +: 8], v.gap, x);
      end
      if (CSUM_EN) send(v.bad_csum ? ~x : x, v.gap, x);
    end
    if (!CSUM_EN && !ovf && v.len > 0) begin
      @(negedge clk);
      chk("done_with_last_write", done, 0);
    end
    @(negedge clk);
    chk("final_done", done, v.exp_done);
    chk("final_err", err, v.exp_err);
    chk("final_cpu_rst", cpu_rst, !v.exp_done);
    chk("final_in_ready", in_ready, 0);
    chk("writes_pending", sb.size(), 0);
    // Terminal state must ignore further bytes.
    in_data  = 8'hA5;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("term_in_ready", in_ready, 0);
    end
    chk("term_done", done, v.exp_done);
    chk("term_err", err, v.exp_err);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] x;
    //           len  gap bad  done      err
    vecs[0] = '{1,    0,  0,   1,        0};
    vecs[1] = '{1,    0,  1,   !CSUM_EN, CSUM_EN};
    vecs[2] = '{0,    0,  0,   1,        0};
    vecs[3] = '{257,  0,  0,   0,        1};
    vecs[4] = '{256,  0,  0,   1,        0};
    vecs[5] = '{2,    3,  0,   1,        0};
    vecs[6] = '{2,    0,  0,   1,        0};

    for (int i = 0; i < 7; i++) begin
      cur_vec = i;
      do_reset();
      run_vec(vecs[i]);
    end

    // Reset mid-word, coinciding with an offered byte: nothing written, then a clean reload.
    cur_vec = 7;
    do_reset();
    x = '0;
    send(8'h00, 0, x);
    send(8'h01, 0, x);
    send(8'h20, 0, x);
    send(8'h01, 0, x);
    rst      = 1'b1;
    in_data  = 8'h00;
    in_valid = 1'b1;
    @(negedge clk);
    chk("mid_rst_cpu_rst", cpu_rst, 1);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_cpu_rst2", cpu_rst, 1);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_pending", sb.size(), 0);
    @(posedge clk);
    #1;
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mips_imem_loader.md
Name: mips_imem_loader

Overview:
- Boot-time program loader for the 5-stage MIPS pipeline: receives a byte stream over a valid/ready interface and writes instruction words into instruction memory.
- Holds the pipeline core in reset until a complete, checksum-verified image is stored, then releases it.
- Sits between an external byte source (UART receiver, debug port or bench driver) and the write port of the instruction memory.
- Counterpart to the write-back result checker: the checker reads results out of the core, this block writes the program into it.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity = 2^ADDR_W words.
- CNT_W, 16, width of the word-count header field; fixed at 16, not overridable.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8  stream byte.
- in_valid  in  1  byte present on in_data.
- in_ready  out  1  loader can accept a byte; a transfer occurs on a cycle with in_valid && in_ready.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  word address (core byte PC = imem_addr<<2).
- imem_wdata  out  32  instruction word.
- cpu_rst  out  1  reset to the pipeline core; high while loading.
- done  out  1  image loaded and verified.
- err  out  1  load failed; sticky until rst.

Behaviour:
- Stream format: LEN_HI, LEN_LO (word count N, 16-bit big-endian), then N words of 4 bytes each, big-endian (MSB first), then a 1-byte CSUM.
- CSUM = XOR of every preceding byte (length bytes and data bytes).
- All outputs are registered.
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, done=0, err=0, FSM=S_LEN_HI, byte/word counters=0, running XOR=0.
- in_ready is 0 on the first cycle after rst deasserts, then 1 in S_LEN_HI, S_LEN_LO, S_DATA and S_CSUM.
- in_ready is 0 in S_DONE and S_ERR.
- FSM transitions (each advances only on an accepted byte):
  - S_LEN_HI -> S_LEN_LO.
  - S_LEN_LO: if N > 2^ADDR_W -> S_ERR; else if N==0 -> S_CSUM; else -> S_DATA.
  - S_DATA: shifts bytes into a 32-bit assembly register. On the 4th byte of a word, imem_we=1 for exactly the next cycle, with imem_addr = word index (0-based) and imem_wdata = the assembled word. After word N-1 -> S_CSUM.
  - S_CSUM: byte == running XOR -> S_DONE; else -> S_ERR.
  - S_DONE and S_ERR are terminal; only rst leaves them.
- done and err rise in the cycle after the deciding byte is accepted.
- cpu_rst falls in the same cycle that done rises. cpu_rst stays 1 in S_ERR.
- The N == 2^ADDR_W boundary is legal (exactly full); the word counter must not wrap before the last write.
- Idle cycles (in_valid=0) anywhere in the stream: state holds, no write, no XOR update.
- rst has priority over a simultaneous byte transfer. The byte is dropped.
- rst mid-load: returns to S_LEN_HI and asserts cpu_rst=1, done=0, err=0. A partially assembled word is discarded with no write. Previously written memory words are not cleared.
- imem_we is never asserted outside S_DATA completion cycles.

Optional Feature:
- Macro LOADER_CSUM_EN.
- Defined: the CSUM byte is required and checked as above.
- Undefined:
  - No CSUM byte is expected.
  - After the last data word (or immediately after LEN_LO when N==0) the FSM goes directly to S_DONE.
  - done rises the cycle after the final imem_we pulse (N==0: the cycle after LEN_LO).
  - err is raised only by length overflow.
  - The XOR logic is not generated.

Test Plan (LOADER_CSUM_EN defined, ADDR_W=8 unless noted):
- Stream 00 01 20 01 00 05 25 -> single imem_we pulse with addr=0, wdata=0x20010005; one cycle after byte 0x25, done=1, cpu_rst=0, err=0, in_ready=0.
- Same stream with CSUM 24 -> one write to addr 0, then err=1, done=0, cpu_rst stays 1, in_ready=0; further bytes are ignored.
- Stream 00 00 00 -> no imem_we; done=1, cpu_rst=0.
- Stream 01 01 -> err=1 one cycle after LEN_LO with no writes; also stream 01 00 + 256 words + correct CSUM -> last write at addr 0xFF, done=1.
- Stream 00 02 20010005 20020007 (+ CSUM) with in_valid low for 3 random cycles between bytes -> writes addr0=0x20010005, addr1=0x20020007; same result as a gap-free stream.
- After 00 01 20 01 pulse rst for 1 cycle, then send 00 01 20 01 00 05 25 -> no write before the restart, cpu_rst=1 through the reset, exactly one write (addr 0, 0x20010005), done=1; with LOADER_CSUM_EN undefined, the stream without 25 gives the same result.
